cpu_step_ctrl: RTL and testbench

Execution controller between the DE1-SoC board inputs and the single-cycle RV32I core. Turns a raw pushbutton and mode switches into a per-cycle `cpu_en` clock-enable for the core, so the core can halt, single-step, run slowly or run at full speed. It also stops at a hardware PC breakpoint and counts retired instructions. The FPGA top drives the core's register/PC update enable from `cpu_en`, and feeds the core's `pc` back in.

---
 rtl/cpu_step_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Execution controller for the single-cycle RV32I core: turns the step key and mode
// switches into a per-clock core enable, with a PC breakpoint and a retired-instruction count.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_step_n,
    input  logic [1:0]  sw_mode,
    input  logic        sw_break_en,
    input  logic [31:0] break_pc,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic        halted,
    output logic        at_break,
    output logic [31:0] retired
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = $clog2(RUN_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        ST_HALT,
        ST_STEP,
        ST_SLOW,
        ST_RUN,
        ST_BREAK
    } state_t;

    logic            r_keyMeta;
    logic            r_keySync;
    logic [1:0]      r_modeMeta;
    logic [1:0]      r_modeSync;
    logic            r_brkMeta;
    logic            r_brkSync;
    logic            r_keyLevel;
    logic [DB_W-1:0] r_dbCnt;
    logic            r_press;
    logic [PS_W-1:0] r_presc;
    logic            r_req;
    logic            r_bypass;
    logic [31:0]     r_retired;
    state_t          r_state;

    state_t          w_modeState;
    state_t          w_nextState;
    logic            w_reqNext;
    logic            w_hit;
    logic            w_tick;
    logic            w_stepIssue;

    // The key idles high, so the synchronizer resets released to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_keyMeta  <= 1'b1;
            r_keySync  <= 1'b1;
            r_modeMeta <= 2'b00;
            r_modeSync <= 2'b00;
            r_brkMeta  <= 1'b0;
            r_brkSync  <= 1'b0;
        end else begin
            r_keyMeta  <= key_step_n;
            r_keySync  <= r_keyMeta;
            r_modeMeta <= sw_mode;
            r_modeSync <= r_modeMeta;
            r_brkMeta  <= sw_break_en;
            r_brkSync  <= r_brkMeta;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_keyLevel <= 1'b1;
            r_dbCnt    <= '0;
            r_press    <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_keySync == r_keyLevel) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == DB_LAST) begin
                r_keyLevel <= r_keySync;
                r_dbCnt    <= '0;
                r_press    <= ~r_keySync;
            end else begin
                r_dbCnt <= r_dbCnt + DB_W'(1);
            end
        end
    end

    always_comb begin
        case (r_modeSync)
            2'b00:   w_modeState = ST_HALT;
            2'b01:   w_modeState = ST_STEP;
            2'b10:   w_modeState = ST_SLOW;
            default: w_modeState = ST_RUN;
        endcase
    end

    assign w_tick      = (r_state == ST_SLOW) && (r_presc == PS_LAST);
    assign w_hit       = r_brkSync && (pc == break_pc) && !r_bypass &&
                         ((r_state == ST_SLOW) || (r_state == ST_RUN));
    assign w_stepIssue = (r_state == ST_BREAK) && r_req;

    // BREAK holds until a press has produced its single enable; a HALT request always wins.
    always_comb begin
        w_nextState = w_modeState;
        w_reqNext   = 1'b0;
        if (r_state == ST_BREAK) begin
            if (r_modeSync == 2'b00) begin
                w_nextState = ST_HALT;
            end else if (!r_req) begin
                w_nextState = ST_BREAK;
                w_reqNext   = r_press;
            end
        end else begin
            if (w_hit && r_req && (w_modeState != ST_HALT)) begin
                w_nextState = ST_BREAK;
            end
            case (r_state)
                ST_SLOW: w_reqNext = w_tick;
                ST_RUN:  w_reqNext = 1'b1;
                default: w_reqNext = 1'b0;
            endcase
            if (r_press && (w_nextState == ST_STEP)) begin
                w_reqNext = 1'b1;
            end
            if (w_nextState == ST_BREAK) begin
                w_reqNext = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HALT;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_req   <= w_reqNext;
        end
    end

    // Held at zero outside SLOW so every entry into SLOW starts a full period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if ((r_state != ST_SLOW) || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // After stepping off a breakpoint, ignore that PC until the core has moved away from it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bypass <= 1'b0;
        end else if (w_stepIssue) begin
            r_bypass <= 1'b1;
        end else if (pc != break_pc) begin
            r_bypass <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else begin
            r_retired <= r_retired + 32'(cpu_en);
        end
    end

    assign cpu_en   = r_req && !w_hit;
    assign halted   = r_state inside {ST_HALT, ST_STEP, ST_BREAK};
    assign at_break = (r_state == ST_BREAK);
    assign retired  = r_retired;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: each expected enable (PC, retired count, spacing)
// is queued by the stimulus and consumed by a monitor whenever cpu_en is seen high.
module tb_cpu_step_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_step_n;
    logic [1:0]  sw_mode;
    logic        sw_break_en;
    logic [31:0] break_pc;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic        at_break;
    logic [31:0] retired;
    logic        pcLoad;
    logic [31:0] pcLoadVal;

    exp_t expQ[$];
    exp_t monItem;
    int   checks;
    int   failures;
    int   monCyc;
    int   lastEnCyc;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_step_n (key_step_n),
        .sw_mode    (sw_mode),
        .sw_break_en(sw_break_en),
        .break_pc   (break_pc),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .at_break   (at_break),
        .retired    (retired)
    );

    // Minimal core model: PC advances by one instruction on each enabled clock.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= 32'h0;
        end else if (pcLoad) begin
            pc <= pcLoadVal;
        end else if (cpu_en) begin
            pc <= pc + 32'd4;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectEnable(input logic [31:0] p, input logic [31:0] r, input int g);
        exp_t e;
        e.pc  = p;
        e.ret = r;
        e.gap = g;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic key, input logic brk, input int cycles);
        sw_mode     = mode;
        key_step_n  = key;
        sw_break_en = brk;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Monitor samples just after each rising edge and pairs every enable with the queue head.
    initial begin
        monCyc    = 0;
        lastEnCyc = 0;
        forever begin
            @(posedge clk);
            #1;
            monCyc++;
            if (reset_n && (cpu_en === 1'b1)) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_enable: cpu_en=1 at pc 0x%08h retired %0d, expected no enable", pc, retired);
                end else begin
                    monItem = expQ.pop_front();
                    checkOutput("enable_pc", pc, monItem.pc);
                    checkOutput("enable_retired", retired, monItem.ret);
                    if (monItem.gap != 0) begin
                        checkOutput("enable_gap", 32'(monCyc - lastEnCyc), 32'(monItem.gap));
                    end
                end
                lastEnCyc = monCyc;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        key_step_n  = 1'b1;
        sw_mode     = 2'b00;
        sw_break_en = 1'b0;
        break_pc    = 32'h10;
        pcLoad      = 1'b0;
        pcLoadVal   = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("reset_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd1);
        checkOutput("reset_at_break", 32'(at_break), 32'd0);
        checkOutput("reset_retired", retired, 32'd0);
        reset_n = 1'b1;
        applyStimulus(2'b00, 1'b1, 1'b0, 100);
        checkOutput("halt_retired", retired, 32'd0);
        checkOutput("halt_halted", 32'(halted), 32'd1);

        // STEP: short glitches must not step; two clean presses step twice.
        applyStimulus(2'b01, 1'b1, 1'b0, 6);
        applyStimulus(2'b01, 1'b0, 1'b0, 2);
        applyStimulus(2'b01, 1'b1, 1'b0, 3);
        applyStimulus(2'b01, 1'b0, 1'b0, 3);
        applyStimulus(2'b01, 1'b1, 1'b0, 8);
        checkOutput("glitch_retired", retired, 32'd0);
        expectEnable(32'h0, 32'd0, 0);
        applyStimulus(2'b01, 1'b0, 1'b0, 10);
        applyStimulus(2'b01, 1'b1, 1'b0, 10);
        waitDrain("step1_drain", 20);
        checkOutput("step1_retired", retired, 32'd1);
        expectEnable(32'h4, 32'd1, 0);
        applyStimulus(2'b01, 1'b0, 1'b0, 10);
        applyStimulus(2'b01, 1'b1, 1'b0, 10);
        waitDrain("step2_drain", 20);
        checkOutput("step2_retired", retired, 32'd2);

        // SLOW for 30 clocks: six enables exactly DIV clocks apart.
        for (int i = 0; i < 6; i++) begin
            expectEnable(32'(8 + 4 * i), 32'(2 + i), (i == 0) ? 0 : DIV);
        end
        applyStimulus(2'b10, 1'b1, 1'b0, 30);
        applyStimulus(2'b00, 1'b1, 1'b0, 10);
        waitDrain("slow_drain", 20);
        checkOutput("slow_retired", retired, 32'd8);

        // RUN, then asynchronous reset in the middle of it.
        for (int i = 0; i < 7; i++) begin
            expectEnable(32'(32'h20 + 4 * i), 32'(8 + i), (i == 0) ? 0 : 1);
        end
        applyStimulus(2'b11, 1'b1, 1'b0, 10);
        checkOutput("run_halted", 32'(halted), 32'd0);
        waitDrain("run_drain", 0);
        reset_n = 1'b0;
        sw_mode = 2'b00;
        #1;
        checkOutput("midrun_reset_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("midrun_reset_retired", retired, 32'd0);
        checkOutput("midrun_reset_halted", 32'(halted), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(2'b00, 1'b1, 1'b0, 100);
        checkOutput("post_reset_retired", retired, 32'd0);

        // Breakpoint at 0x10: four enables, then BREAK with the 0x10 instruction held.
        for (int i = 0; i < 4; i++) begin
            expectEnable(32'(4 * i), 32'(i), (i == 0) ? 0 : 1);
        end
        applyStimulus(2'b11, 1'b1, 1'b1, 12);
        checkOutput("brk_at_break", 32'(at_break), 32'd1);
        checkOutput("brk_retired", retired, 32'd4);
        checkOutput("brk_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("brk_halted", 32'(halted), 32'd1);
        waitDrain("brk_run_drain", 0);
        expectEnable(32'h10, 32'd4, 0);
        for (int i = 0; i < 10; i++) begin
            expectEnable(32'(32'h14 + 4 * i), 32'(5 + i), (i == 0) ? 2 : 1);
        end
        applyStimulus(2'b11, 1'b0, 1'b1, 10);
        applyStimulus(2'b11, 1'b1, 1'b1, 5);
        checkOutput("brk_resume_at_break", 32'(at_break), 32'd0);
        checkOutput("brk_resume_halted", 32'(halted), 32'd0);
        applyStimulus(2'b00, 1'b1, 1'b1, 10);
        waitDrain("brk_resume_drain", 20);
        checkOutput("brk_resume_retired", retired, 32'd15);

        // BREAK left via HALT, then RUN resumes with the breakpoint disabled.
        pcLoadVal = 32'h0;
        pcLoad    = 1'b1;
        @(negedge clk);
        pcLoad    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expectEnable(32'(4 * i), 32'(15 + i), (i == 0) ? 0 : 1);
        end
        applyStimulus(2'b11, 1'b1, 1'b1, 12);
        checkOutput("brk2_at_break", 32'(at_break), 32'd1);
        checkOutput("brk2_retired", retired, 32'd19);
        applyStimulus(2'b00, 1'b1, 1'b1, 6);
        checkOutput("brk2_halt_at_break", 32'(at_break), 32'd0);
        checkOutput("brk2_halt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 6; i++) begin
            expectEnable(32'(32'h10 + 4 * i), 32'(19 + i), (i == 0) ? 0 : 1);
        end
        applyStimulus(2'b11, 1'b1, 1'b0, 6);
        checkOutput("brk2_run_halted", 32'(halted), 32'd0);
        applyStimulus(2'b00, 1'b1, 1'b0, 10);
        waitDrain("brk2_run_drain", 20);
        checkOutput("brk2_run_retired", retired, 32'd25);

        // Retired counter wrap from 0xFFFF_FFFE through two enables.
        force dut.r_retired = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_retired;
        expectEnable(32'h28, 32'hFFFF_FFFE, 0);
        expectEnable(32'h2C, 32'hFFFF_FFFF, 1);
        applyStimulus(2'b11, 1'b1, 1'b0, 2);
        applyStimulus(2'b00, 1'b1, 1'b0, 10);
        waitDrain("wrap_drain", 20);
        checkOutput("wrap_retired", retired, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
